btn_conditioner: RTL and testbench

Parametrised multi-channel push-button front end for board top levels. Per channel it provides:
- optional input polarity inversion;
- 2-flop synchroniser;
- counter-based debounce;
- press/release edge pulses;
- long-press detection;
- optional auto-repeat.

It replaces one single-channel debouncer instance per button. Its outputs drive calculator/UART core command inputs directly.

---
 rtl/btn_conditioner.sv | 154 +++++++++++++++
 tb/tb_btn_conditioner.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end: sync, debounce, edges, long-press.
// Optional auto-repeat of Press while held: define BTN_COND_REPEAT_EN.
module btn_conditioner #(
  parameter int CHANNELS        = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int LONG_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [CHANNELS-1:0] BtnRaw,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] LongPress,
  output logic [CHANNELS-1:0] LongHeld
);

  localparam int HOLD_MAX =
    (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_MAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
`ifdef BTN_COND_REPEAT_EN
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
`else
  localparam logic [HW-1:0] HOLD_TOP  = HW'(HOLD_MAX);
`endif

  typedef enum logic [1:0] {
    IDLE,
    HELD,
    LONG
  } hold_e;

  logic [CHANNELS-1:0] p;
  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] acc_press;
  logic [CHANNELS-1:0] acc_rel;

  logic [DW-1:0] db_cnt   [CHANNELS];
  logic [HW-1:0] hold_cnt [CHANNELS];
  hold_e         state    [CHANNELS];

  // Map pins to "1 = pressed" before they enter the synchroniser.
  assign p = (ACTIVE_LOW != 0) ? ~BtnRaw : BtnRaw;

  // A level change is accepted on the cycle its stable run completes.
  always_comb begin
    hit = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = (s2[i] != Level[i]) && (db_cnt[i] == DB_LAST);
    end
    acc_press = hit & s2;
    acc_rel   = hit & ~s2;
  end

  // Synchroniser, debounce counter and debounced level per channel.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      s1    <= '0;
      s2    <= '0;
      Level <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      s1 <= p;
      s2 <= s1;
      for (int i = 0; i < CHANNELS; i++) begin
        if (s2[i] == Level[i]) begin
          db_cnt[i] <= '0;
        end else if (hit[i]) begin
          db_cnt[i] <= '0;
          Level[i]  <= s2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Hold FSM: edge pulses, long-press timing and optional repeats.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      Press     <= '0;
      Release   <= '0;
      LongPress <= '0;
      LongHeld  <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        state[i]    <= IDLE;
        hold_cnt[i] <= '0;
      end
    end else begin
      Press     <= '0;
      Release   <= '0;
      LongPress <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        if (acc_rel[i]) begin
          // Release wins over a long-press or repeat due this cycle.
          state[i]    <= IDLE;
          hold_cnt[i] <= '0;
          Release[i]  <= 1'b1;
          LongHeld[i] <= 1'b0;
        end else begin
          unique case (state[i])
            IDLE: begin
              if (acc_press[i]) begin
                state[i]    <= HELD;
                hold_cnt[i] <= '0;
                Press[i]    <= 1'b1;
              end
            end
            HELD: begin
              if (hold_cnt[i] == LONG_LAST) begin
                state[i]     <= LONG;
                hold_cnt[i]  <= '0;
                LongPress[i] <= 1'b1;
                LongHeld[i]  <= 1'b1;
              end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
            end
            LONG: begin
`ifdef BTN_COND_REPEAT_EN
              // Counter doubles as the repeat timer, wrapping per pulse.
              if (hold_cnt[i] == REP_LAST) begin
                hold_cnt[i] <= '0;
                Press[i]    <= 1'b1;
              end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
`else
              if (hold_cnt[i] != HOLD_TOP) begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
`endif
            end
            default: begin
              state[i]    <= IDLE;
              hold_cnt[i] <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed scenarios plus random button activity
// checked against a run-length/timestamp reference model.
module tb_btn_conditioner;

  localparam int N = 4;
  localparam int D = 4;
  localparam int L = 10;
  localparam int R = 3;

  logic         Clk = 1'b0;
  logic         RstN = 1'b0;
  logic [N-1:0] BtnRaw = '1;
  logic [N-1:0] Level;
  logic [N-1:0] Press;
  logic [N-1:0] Release;
  logic [N-1:0] LongPress;
  logic [N-1:0] LongHeld;

  btn_conditioner #(
    .CHANNELS        (N),
    .ACTIVE_LOW      (1),
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .REPEAT_CYCLES   (R)
  ) dut (
    .Clk       (Clk),
    .RstN      (RstN),
    .BtnRaw    (BtnRaw),
    .Level     (Level),
    .Press     (Press),
    .Release   (Release),
    .LongPress (LongPress),
    .LongHeld  (LongHeld)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Model: pressed samples delayed two edges, run length of the delayed
  // stream, accepted level, and the edge number of the last press.
  int pd1 [N];
  int pd2 [N];
  int run_val [N];
  int run_len [N];
  int lvl [N];
  int press_t [N];
  int cyc = 0;

  logic [N-1:0] e_level, e_press, e_rel, e_long, e_held;

  task automatic check(input string tag, input logic [N-1:0] obs,
                       input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      pd1[c] = 0;
      pd2[c] = 0;
      run_val[c] = 0;
      run_len[c] = 0;
      lvl[c] = 0;
    end
    e_level = '0;
    e_press = '0;
    e_rel = '0;
    e_long = '0;
    e_held = '0;
  endtask

  task automatic model_edge();
    int s, prev, age;
    cyc++;
    for (int c = 0; c < N; c++) begin
      s = pd2[c];
      pd2[c] = pd1[c];
      pd1[c] = BtnRaw[c] ? 0 : 1;
      if (s == run_val[c]) run_len[c]++;
      else begin
        run_val[c] = s;
        run_len[c] = 1;
      end
      prev = lvl[c];
      if (run_val[c] != lvl[c] && run_len[c] >= D) lvl[c] = run_val[c];
      e_press[c] = 1'b0;
      e_rel[c] = 1'b0;
      e_long[c] = 1'b0;
      e_held[c] = 1'b0;
      if (lvl[c] == 1 && prev == 0) begin
        e_press[c] = 1'b1;
        press_t[c] = cyc;
      end
      if (lvl[c] == 0 && prev == 1) e_rel[c] = 1'b1;
      age = cyc - press_t[c];
      if (lvl[c] == 1 && prev == 1) begin
        if (age == L) e_long[c] = 1'b1;
        if (age >= L) e_held[c] = 1'b1;
`ifdef BTN_COND_REPEAT_EN
        if (age > L && ((age - L) % R) == 0) e_press[c] = 1'b1;
`endif
      end
      e_level[c] = lvl[c][0];
    end
  endtask

  task automatic step();
    @(posedge Clk);
    if (RstN) model_edge();
    else model_reset();
    #1;
    check("level", Level, e_level);
    check("press", Press, e_press);
    check("release", Release, e_rel);
    check("longpress", LongPress, e_long);
    check("longheld", LongHeld, e_held);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    bit found;
    for (int c = 0; c < N; c++) press_t[c] = 0;
    model_reset();

    // Reset held with every button pressed.
    BtnRaw = 4'b0000;
    RstN = 1'b0;
    #1;
    check("rst_async_level", Level, 4'b0000);
    check("rst_async_press", Press, 4'b0000);
    run(3);
    RstN = 1'b1;
    run(5);
    check("rst_edge5_level", Level, 4'b0000);
    step();
    check("rst_edge6_level", Level, 4'b1111);
    check("rst_edge6_press", Press, 4'b1111);
    step();
    check("rst_edge7_press", Press, 4'b0000);
    BtnRaw = 4'b1111;
    run(12);

    // Clean press and release on channel 0.
    BtnRaw[0] = 1'b0;
    run(15);
    BtnRaw[0] = 1'b1;
    run(10);

    // Bouncing channel 1 never gets accepted.
    for (int i = 0; i < 10; i++) begin
      BtnRaw[1] = ~BtnRaw[1];
      run(2);
      check("bounce_level", Level & 4'b0010, 4'b0000);
    end
    BtnRaw[1] = 1'b1;
    run(8);

    // Long press on channel 2.
    BtnRaw[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (Press[2]) found = 1'b1;
    end
    check("lp_press_seen", found ? 4'b0100 : 4'b0000, 4'b0100);
    run(9);
    check("lp_p9_long", LongPress & 4'b0100, 4'b0000);
    step();
    check("lp_p10_long", LongPress & 4'b0100, 4'b0100);
    check("lp_p10_held", LongHeld & 4'b0100, 4'b0100);
    run(14);
    BtnRaw[2] = 1'b1;
    run(10);

    // Channels 0 and 3 together; channel 0 released right at P+10.
    BtnRaw = 4'b0110;
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      step();
      if (Press != 4'b0000) found = 1'b1;
    end
    check("sim_press", Press, 4'b1001);
    run(4);
    BtnRaw[0] = 1'b1;
    run(5);
    step();
    check("bnd_release", Release & 4'b0001, 4'b0001);
    check("bnd_long", LongPress & 4'b1001, 4'b1000);
    check("bnd_held", LongHeld & 4'b1001, 4'b1000);
    BtnRaw = 4'b1111;
    run(12);

    // Reset while channel 2 is held: re-pressed after full latency.
    BtnRaw[2] = 1'b0;
    run(8);
    check("mid_level", Level, 4'b0100);
    RstN = 1'b0;
    model_reset();
    #1;
    check("mid_async_level", Level, 4'b0000);
    check("mid_async_held", LongHeld, 4'b0000);
    run(2);
    RstN = 1'b1;
    run(5);
    check("mid_edge5_level", Level, 4'b0000);
    step();
    check("mid_edge6_press", Press, 4'b0100);
    BtnRaw = 4'b1111;
    run(12);

    // Long hold on channel 1 (repeats when enabled).
    BtnRaw[1] = 1'b0;
    run(40);
    BtnRaw[1] = 1'b1;
    run(12);

    // Random activity: fast toggling on 0-2, slow on 3, rare resets.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 3; c++) begin
        if ($urandom_range(0, 9) == 0) BtnRaw[c] = ~BtnRaw[c];
      end
      if ($urandom_range(0, 39) == 0) BtnRaw[3] = ~BtnRaw[3];
      if ($urandom_range(0, 999) == 0) begin
        RstN = 1'b0;
        step();
        RstN = 1'b1;
      end else begin
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
